// File: rtl/krnl_acc_ctrl_regfile.sv
// AXI4-Lite control slave for the convolution kernel: ap_ctrl_chain CTRL, config words, 64-bit pointers.
// Optional interrupt block (GIE/IER/ISR, interrupt) is built only when KRNL_ACC_CTRL_INTR_EN is defined.
module krnl_acc_ctrl_regfile #(
   parameter int                ADDR_W   = 12,
   parameter int                NUM_CFG  = 6,
   parameter int                NUM_PTR  = 3,
   parameter logic [ADDR_W-1:0] CFG_BASE = 12'h010,
   parameter logic [ADDR_W-1:0] PTR_BASE = 12'h040
) (
   input  logic                   ACLK,
   input  logic                   ARESETn,
   input  logic [ADDR_W-1:0]      AWADDR,
   input  logic                   AWVALID,
   output logic                   AWREADY,
   input  logic [31:0]            WDATA,
   input  logic [3:0]             WSTRB,
   input  logic                   WVALID,
   output logic                   WREADY,
   output logic [1:0]             BRESP,
   output logic                   BVALID,
   input  logic                   BREADY,
   input  logic [ADDR_W-1:0]      ARADDR,
   input  logic                   ARVALID,
   output logic                   ARREADY,
   output logic [31:0]            RDATA,
   output logic [1:0]             RRESP,
   output logic                   RVALID,
   input  logic                   RREADY,
   output logic                   ap_start,
   output logic                   ap_continue,
   input  logic                   ap_done,
   input  logic                   ap_idle,
   input  logic                   ap_ready,
   output logic [NUM_CFG*32-1:0]  cfg,
   output logic [NUM_PTR*64-1:0]  ptr,
   output logic                   interrupt
);

   localparam logic [1:0] WRRESET = 2'd0;
   localparam logic [1:0] WRIDLE  = 2'd1;
   localparam logic [1:0] WRDATA  = 2'd2;
   localparam logic [1:0] WRRESP  = 2'd3;

   localparam logic [1:0] RDRESET = 2'd0;
   localparam logic [1:0] RDIDLE  = 2'd1;
   localparam logic [1:0] RDDATA  = 2'd2;

   localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(12'h000);
   localparam logic [ADDR_W-1:0] A_GIE  = ADDR_W'(12'h004);
   localparam logic [ADDR_W-1:0] A_IER  = ADDR_W'(12'h008);
   localparam logic [ADDR_W-1:0] A_ISR  = ADDR_W'(12'h00C);

   // Handshakes: a beat transfers on a rising edge where valid and ready are both high;
   // valid never depends on ready, and payload is held stable while valid waits for ready.
   function automatic logic [NUM_CFG-1:0] cfg_sel(input logic [ADDR_W-1:0] a);
      logic [NUM_CFG-1:0] s;
      s = '0;
      for (int i = 0; i < NUM_CFG; i++) s[i] = (a == CFG_BASE + ADDR_W'(4 * i));
      return s;
   endfunction

   function automatic logic [NUM_PTR-1:0] ptr_sel(input logic [ADDR_W-1:0] a, input int off);
      logic [NUM_PTR-1:0] s;
      s = '0;
      for (int i = 0; i < NUM_PTR; i++) s[i] = (a == PTR_BASE + ADDR_W'(8 * i + off));
      return s;
   endfunction

   logic [1:0]        wr_state, rd_state;
   logic [ADDR_W-1:0] waddr_q;
   logic [1:0]        bresp_q, rresp_q;
   logic [31:0]       rdata_q;

   logic [31:0]       cfg_q [NUM_CFG];
   logic [63:0]       ptr_q [NUM_PTR];

   logic              start_r, auto_restart_r, cont_r, done_r, idle_r, ready_r;

   logic [NUM_CFG-1:0] w_cfg, r_cfg;
   logic [NUM_PTR-1:0] w_plo, w_phi, r_plo, r_phi;
   logic               w_ctrl, w_gie, w_ier, w_isr, w_ok;
   logic               r_ctrl, r_gie, r_ier, r_isr, r_ok;
   logic               wr_en, ar_hs, ctrl_wr, ctrl_rd, done_bit;
   logic [31:0]        wmask, rd_mux;

   always_comb begin
      w_cfg  = cfg_sel(waddr_q);
      w_plo  = ptr_sel(waddr_q, 0);
      w_phi  = ptr_sel(waddr_q, 4);
      w_ctrl = (waddr_q == A_CTRL);
      w_gie  = (waddr_q == A_GIE);
      w_ier  = (waddr_q == A_IER);
      w_isr  = (waddr_q == A_ISR);
      w_ok   = (|w_cfg) | (|w_plo) | (|w_phi) | w_ctrl | w_gie | w_ier | w_isr;
      r_cfg  = cfg_sel(ARADDR);
      r_plo  = ptr_sel(ARADDR, 0);
      r_phi  = ptr_sel(ARADDR, 4);
      r_ctrl = (ARADDR == A_CTRL);
      r_gie  = (ARADDR == A_GIE);
      r_ier  = (ARADDR == A_IER);
      r_isr  = (ARADDR == A_ISR);
      r_ok   = (|r_cfg) | (|r_plo) | (|r_phi) | r_ctrl | r_gie | r_ier | r_isr;
   end

   assign AWREADY = (wr_state == WRIDLE);
   assign WREADY  = (wr_state == WRDATA);
   assign BVALID  = (wr_state == WRRESP);
   assign BRESP   = bresp_q;
   assign ARREADY = (rd_state == RDIDLE);
   assign RVALID  = (rd_state == RDDATA);
   assign RDATA   = rdata_q;
   assign RRESP   = rresp_q;

   // Unmapped or misaligned addresses never enable a register update.
   assign wr_en    = (wr_state == WRDATA) && WVALID && w_ok;
   assign ar_hs    = (rd_state == RDIDLE) && ARVALID;
   assign ctrl_wr  = wr_en && w_ctrl;
   assign ctrl_rd  = ar_hs && r_ctrl;
   assign wmask    = {{8{WSTRB[3]}}, {8{WSTRB[2]}}, {8{WSTRB[1]}}, {8{WSTRB[0]}}};
   assign done_bit = done_r | ap_done;

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         wr_state <= WRRESET;
         waddr_q  <= '0;
         bresp_q  <= 2'b00;
      end else begin
         case (wr_state)
            WRRESET: wr_state <= WRIDLE;
            WRIDLE: if (AWVALID) begin
               waddr_q  <= AWADDR;
               wr_state <= WRDATA;
            end
            WRDATA: if (WVALID) begin
               bresp_q  <= w_ok ? 2'b00 : 2'b10;
               wr_state <= WRRESP;
            end
            WRRESP: if (BREADY) wr_state <= WRIDLE;
            default: wr_state <= WRIDLE;
         endcase
      end
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         rd_state <= RDRESET;
         rdata_q  <= '0;
         rresp_q  <= 2'b00;
      end else begin
         case (rd_state)
            RDRESET: rd_state <= RDIDLE;
            RDIDLE: if (ARVALID) begin
               rdata_q  <= rd_mux;
               rresp_q  <= r_ok ? 2'b00 : 2'b10;
               rd_state <= RDDATA;
            end
            RDDATA: if (RREADY) rd_state <= RDIDLE;
            default: rd_state <= RDIDLE;
         endcase
      end
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         start_r        <= 1'b0;
         auto_restart_r <= 1'b0;
         cont_r         <= 1'b0;
         done_r         <= 1'b0;
         idle_r         <= 1'b0;
         ready_r        <= 1'b0;
      end else begin
         // A host start request wins over a coincident ap_ready.
         if (ctrl_wr && WSTRB[0] && WDATA[0]) start_r <= 1'b1;
         else if (ap_ready && !auto_restart_r) start_r <= 1'b0;
         if (ctrl_wr && WSTRB[0]) auto_restart_r <= WDATA[7];
         cont_r <= ctrl_wr && WDATA[4];
         if (ap_done) done_r <= 1'b1;
         else if (ctrl_rd) done_r <= 1'b0;
         idle_r  <= ap_idle;
         ready_r <= ap_ready;
      end
   end

   assign ap_start    = start_r;
   assign ap_continue = cont_r;

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         for (int i = 0; i < NUM_CFG; i++) cfg_q[i] <= '0;
         for (int i = 0; i < NUM_PTR; i++) ptr_q[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_CFG; i++)
            if (wr_en && w_cfg[i]) cfg_q[i] <= (cfg_q[i] & ~wmask) | (WDATA & wmask);
         for (int i = 0; i < NUM_PTR; i++) begin
            if (wr_en && w_plo[i]) ptr_q[i][31:0]  <= (ptr_q[i][31:0]  & ~wmask) | (WDATA & wmask);
            if (wr_en && w_phi[i]) ptr_q[i][63:32] <= (ptr_q[i][63:32] & ~wmask) | (WDATA & wmask);
         end
      end
   end

   for (genvar g = 0; g < NUM_CFG; g++) begin : g_cfg
      assign cfg[32*g +: 32] = cfg_q[g];
   end
   for (genvar g = 0; g < NUM_PTR; g++) begin : g_ptr
      assign ptr[64*g +: 64] = ptr_q[g];
   end

`ifdef KRNL_ACC_CTRL_INTR_EN
   logic       gie_r, irq_r;
   logic [1:0] ier_r, isr_r, isr_tog;

   assign isr_tog = (wr_en && w_isr && WSTRB[0]) ? WDATA[1:0] : 2'b00;

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         gie_r <= 1'b0;
         ier_r <= 2'b00;
         isr_r <= 2'b00;
         irq_r <= 1'b0;
      end else begin
         if (wr_en && w_gie && WSTRB[0]) gie_r <= WDATA[0];
         if (wr_en && w_ier && WSTRB[0]) ier_r <= WDATA[1:0];
         // Enabled events override a toggle-to-clear in the same cycle.
         isr_r <= (isr_r ^ isr_tog) | (ier_r & {ap_ready, ap_done});
         irq_r <= gie_r & (|isr_r);
      end
   end

   assign interrupt = irq_r;
`else
   assign interrupt = 1'b0;
`endif

   always_comb begin
      rd_mux = '0;
      if (r_ctrl)
         rd_mux = {24'b0, auto_restart_r, 3'b000, ready_r, idle_r, done_bit, start_r};
      for (int i = 0; i < NUM_CFG; i++)
         if (r_cfg[i]) rd_mux = cfg_q[i];
      for (int i = 0; i < NUM_PTR; i++) begin
         if (r_plo[i]) rd_mux = ptr_q[i][31:0];
         if (r_phi[i]) rd_mux = ptr_q[i][63:32];
      end
`ifdef KRNL_ACC_CTRL_INTR_EN
      if (r_gie) rd_mux = {31'b0, gie_r};
      if (r_ier) rd_mux = {30'b0, ier_r};
      if (r_isr) rd_mux = {30'b0, isr_r};
`endif
   end

endmodule
